// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-add-3), one input bit per clock.
// Feeds the score/credit display path; valid/ready handshake on both sides.

// One BCD digit of the double-dabble chain: add-3 adjust, then shift left by one.
module bin_to_bcd_digit (
    input  logic [3:0] din,
    input  logic       cin,
    output logic [3:0] dout,
    output logic       cout
);
    logic [3:0] adj;

    // din <= 9 on entry, so the +3 result never exceeds 4'd12
    always_comb begin
        adj  = (din >= 4'd5) ? din + 4'd3 : din;
        dout = {adj[2:0], cin};
        cout = adj[3];
    end
endmodule

module bin_to_bcd_seq #(
    parameter int XLEN   = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_ovf
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [XLEN-1:0]        bin_sr;
    logic [DIGITS-1:0][3:0] bcd;
    logic [DIGITS-1:0][3:0] bcd_nxt;
    logic [DIGITS:0]        carry;
    logic [CW-1:0]          cnt;
    logic                   ovf;
    logic                   last;

    // Carry chain: binary MSB enters digit 0, top digit's bit 3 falls off the end
    assign carry[0] = bin_sr[XLEN-1];

    bin_to_bcd_digit u_dig [DIGITS-1:0] (
        .din  (bcd),
        .cin  (carry[DIGITS-1:0]),
        .dout (bcd_nxt),
        .cout (carry[DIGITS:1])
    );

    assign last      = (cnt == CW'(1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_bcd   = bcd;
    assign out_ovf   = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr <= '0;
            bcd    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    bin_sr <= in_data;
                    bcd    <= '0;
                    cnt    <= CW'(XLEN);
                    ovf    <= 1'b0;
                end
                SHIFT: begin
                    bcd    <= bcd_nxt;
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt - CW'(1);
                    // any digit carried past the top means value >= 10^DIGITS
                    if (carry[DIGITS]) ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
